prog_mem_wb: RTL
================

PROG_MEM_WB -- requirements
Module: prog_mem_wb

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width; depth = 2^(ADDR_W-2) 32-bit words.
REQ-002 Parameter READ_LAT, default 1, read latency in cycles for both ports; legal values 1 or 2.
REQ-003 Parameter WB_WRITABLE, default 0, 1 enables Wishbone writes; 0 makes the Wishbone port read-only.
REQ-004 Parameter SUBWORD_SHIFT, default 1, 1 right-justifies Wishbone read data by wb_adr_i[1:0] with zero fill.
REQ-005 One clock and synchronous active-high reset: ports clk and rst.
REQ-006 clk  in  1  clock, all logic on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 fetch_req  in  1  instruction fetch request.
REQ-009 fetch_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
REQ-010 fetch_stall  in  1  freezes the fetch pipeline and outputs.
REQ-011 fetch_data  out  32  fetched instruction word.
REQ-012 fetch_valid  out  1  fetch_data valid.
REQ-013 load_we  in  1  boot-loader word write strobe.
REQ-014 load_addr  in  ADDR_W  loader byte address.
REQ-015 load_wdata  in  32  loader write data.
REQ-016 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic control.
REQ-017 wb_adr_i  in  32  Wishbone byte address; wb_dat_i  in  32  write data; wb_sel_i  in  4  byte selects.
REQ-018 wb_dat_o  out  32  read data; wb_ack_o  out  1  ack; wb_err_o  out  1  error.

Function
REQ-019 Word index is addr[ADDR_W-1:2] on all ports.
REQ-020 Fetch: with fetch_stall low, fetch_req sampled at edge N yields fetch_valid=1 and the word at edge N+READ_LAT, one result per requesting cycle, fully pipelined.
REQ-021 With fetch_stall high, no pipeline stage advances, no new request is sampled, and fetch_data/fetch_valid hold their values.
REQ-022 load_we high writes load_wdata to its word that cycle, overrides any fetch_req in the same cycle (that slot returns fetch_valid=0), and blocks Wishbone acceptance.
REQ-023 A same-word read and write in one cycle return the old data (read-before-write) on the reading port.
REQ-024 Wishbone FSM states: IDLE, WAIT, ACK, ERR.
REQ-025 IDLE: a request (wb_cyc_i & wb_stb_i & !load_we) is accepted; wb_adr_i[1:0] is latched.
REQ-026 An accepted request goes to ERR if wb_adr_i[31:ADDR_W] is nonzero, or if wb_we_i=1 with WB_WRITABLE=0; no memory access is made.
REQ-027 Accepted legal write: bytes with wb_sel_i set are written in the acceptance cycle; next state ACK.
REQ-028 Accepted legal read: next state WAIT when READ_LAT=2 (one cycle), else ACK; wb_dat_o is valid in the ACK cycle.
REQ-029 ACK drives wb_ack_o=1 for exactly one cycle; ERR drives wb_err_o=1 for exactly one cycle; both return to IDLE, so back-to-back requests are separated by at least one IDLE cycle.
REQ-030 wb_cyc_i low in WAIT aborts to IDLE with no ack; a write already committed in its acceptance cycle stays committed.
REQ-031 With SUBWORD_SHIFT=1, read data for latched offset k is word>>(8k) zero-filled; with SUBWORD_SHIFT=0 the full word is returned.
REQ-032 wb_dat_o holds its last value outside ACK; wb_ack_o and wb_err_o are never high together.

Reset
REQ-033 rst high at an edge forces: FSM IDLE, fetch pipeline emptied, fetch_valid=0, fetch_data=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
REQ-034 Reset mid-transaction drops it silently with no ack or error; memory contents are not cleared by reset.
REQ-035 A request with stb high in the first cycle after rst deasserts is accepted normally.

Verification
REQ-036 Load 0x00000013 to addr 0x004, fetch 0x004 at READ_LAT=1 -> fetch_valid and 0x00000013 one cycle later; at READ_LAT=2, two cycles later.
REQ-037 Fetches at 0x0, 0x4, 0x8 with fetch_stall high in cycle 2 -> three valid results in order; outputs held during the stall.
REQ-038 WB read of word 0xAABBCCDD at adr 0x...003, SUBWORD_SHIFT=1 -> wb_ack_o one pulse, wb_dat_o=0x000000AA.
REQ-039 WB write wb_sel_i=4'b0011, data 0x11223344 over 0xFFFFFFFF, WB_WRITABLE=1 -> read back 0xFFFF3344; with WB_WRITABLE=0 -> wb_err_o pulse and word unchanged.
REQ-040 WB adr 0x00001000 with ADDR_W=12 -> wb_err_o pulse, no ack; a same-cycle load_we and WB request -> WB is accepted the cycle after load_we drops.
REQ-041 rst asserted in WAIT (READ_LAT=2) -> no ack, all outputs zero next cycle; a new read after reset completes normally.

Source files
------------

// File: rtl/prog_mem_wb.sv
// Program memory with a pipelined instruction-fetch port, a boot-loader write port
// and a Wishbone classic slave port. All three share one word-organised array.
module prog_mem_wb #(
    parameter int unsigned ADDR_W        = 12,
    parameter int unsigned READ_LAT      = 1,
    parameter int unsigned WB_WRITABLE   = 0,
    parameter int unsigned SUBWORD_SHIFT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_stall,
    output logic [31:0]       fetch_data,
    output logic              fetch_valid,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_wdata,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_ERR
    } wb_state_e;

    logic [31:0]      mem_q [DEPTH];
    wb_state_e        state_q, state_d;

    logic [IDX_W-1:0] fetch_idx_c, load_idx_c, wb_idx_c;
    logic             fetch_take_c;
    logic             wb_req_c, wb_bad_c, wb_accept_c, wb_wr_c, wb_rd_c;

    logic             fs1_v_q;
    logic [31:0]      fs1_w_q;
    logic             fetch_valid_q;
    logic [31:0]      fetch_data_q;

    logic             wb_ack_q, wb_err_q;
    logic [31:0]      wb_dat_q, wb_rd_word_q;
    logic [1:0]       wb_off_q;

    function automatic logic [31:0] sub_shift(input logic [31:0] word, input logic [1:0] k);
        if (SUBWORD_SHIFT != 0) begin
            return word >> {k, 3'b000};
        end
        return word;
    endfunction

    assign fetch_idx_c  = fetch_addr[ADDR_W-1:2];
    assign load_idx_c   = load_addr[ADDR_W-1:2];
    assign wb_idx_c     = wb_adr_i[ADDR_W-1:2];

    // Loader owns the array for the cycle it writes, so fetch and Wishbone back off.
    assign fetch_take_c = fetch_req & ~fetch_stall & ~load_we;
    assign wb_req_c     = wb_cyc_i & wb_stb_i & ~load_we & ~rst;
    assign wb_bad_c     = ((wb_adr_i >> ADDR_W) != 32'd0) | (wb_we_i & (WB_WRITABLE == 0));
    assign wb_accept_c  = (state_q == ST_IDLE) & wb_req_c;
    assign wb_wr_c      = wb_accept_c & ~wb_bad_c & wb_we_i;
    assign wb_rd_c      = wb_accept_c & ~wb_bad_c & ~wb_we_i;

    // Memory array: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem_q[load_idx_c] <= load_wdata;
        end else if (wb_wr_c) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem_q[wb_idx_c][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    // Fetch pipeline; a stall freezes every stage including the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fs1_v_q       <= 1'b0;
            fs1_w_q       <= 32'd0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= 32'd0;
        end else if (!fetch_stall) begin
            fs1_v_q <= fetch_take_c;
            if (fetch_take_c) begin
                fs1_w_q <= mem_q[fetch_idx_c];
            end
            if (READ_LAT == 2) begin
                fetch_valid_q <= fs1_v_q;
                if (fs1_v_q) begin
                    fetch_data_q <= fs1_w_q;
                end
            end else begin
                fetch_valid_q <= fetch_take_c;
                if (fetch_take_c) begin
                    fetch_data_q <= mem_q[fetch_idx_c];
                end
            end
        end
    end

    // Wishbone FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Wishbone FSM next state; ACK and ERR always fall back through IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wb_req_c) begin
                    if (wb_bad_c) begin
                        state_d = ST_ERR;
                    end else if (wb_we_i || (READ_LAT != 2)) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: state_d = wb_cyc_i ? ST_ACK : ST_IDLE;
            ST_ACK:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Wishbone registered outputs; read data only changes when entering ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_q     <= 1'b0;
            wb_err_q     <= 1'b0;
            wb_dat_q     <= 32'd0;
            wb_rd_word_q <= 32'd0;
            wb_off_q     <= 2'd0;
        end else begin
            wb_ack_q <= (state_d == ST_ACK);
            wb_err_q <= (state_d == ST_ERR);
            if (wb_accept_c) begin
                wb_off_q <= wb_adr_i[1:0];
            end
            if (wb_rd_c) begin
                wb_rd_word_q <= mem_q[wb_idx_c];
            end
            if (wb_rd_c && (READ_LAT != 2)) begin
                wb_dat_q <= sub_shift(mem_q[wb_idx_c], wb_adr_i[1:0]);
            end else if ((state_q == ST_WAIT) && wb_cyc_i) begin
                wb_dat_q <= sub_shift(wb_rd_word_q, wb_off_q);
            end
        end
    end

    assign fetch_data  = fetch_data_q;
    assign fetch_valid = fetch_valid_q;
    assign wb_dat_o    = wb_dat_q;
    assign wb_ack_o    = wb_ack_q;
    assign wb_err_o    = wb_err_q;

endmodule
